// File: rtl/cmplx_mult_seq.sv
// Sequential complex multiplier: (a+jb)(c+jd) computed with one shared unsigned multiplier over four cycles.
// Optional macro CMPLX_MULT_SEQ_OPCNT_EN adds a 16-bit op_count port counting output handshakes.

module cmplx_mult_seq_umul #(
  parameter int DWIDTH = 8
) (
  input  logic [DWIDTH-1:0]   a,
  input  logic [DWIDTH-1:0]   b,
  output logic [2*DWIDTH-1:0] p
);
  logic [2*DWIDTH-1:0] pp [DWIDTH];

  // Shift-and-add array: one partial product per bit of b.
  generate
    for (genvar gi = 0; gi < DWIDTH; gi++) begin : g_pp
      assign pp[gi] = b[gi] ? ({{DWIDTH{1'b0}}, a} << gi) : '0;
    end
  endgenerate

  always_comb begin
    p = '0;
    for (int i = 0; i < DWIDTH; i++) begin
      p = p + pp[i];
    end
  end
endmodule

module cmplx_mult_seq #(
  parameter int DWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DWIDTH-1:0]   in_a,
  input  logic [DWIDTH-1:0]   in_b,
  input  logic [DWIDTH-1:0]   in_c,
  input  logic [DWIDTH-1:0]   in_d,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DWIDTH:0]   out_re,
  output logic [2*DWIDTH:0]   out_im
`ifdef CMPLX_MULT_SEQ_OPCNT_EN
  ,
  output logic [15:0]         op_count
`endif
);
  localparam int RW = 2 * DWIDTH + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL_AC = 3'd1,
    MUL_BD = 3'd2,
    MUL_AD = 3'd3,
    MUL_BC = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t              state_reg;
  logic [DWIDTH-1:0]   a_reg, b_reg, c_reg, d_reg;
  logic [RW-1:0]       re_acc_reg, im_acc_reg;
  logic [RW-1:0]       out_re_reg, out_im_reg;
  logic                in_ready_reg, out_valid_reg;

  logic [DWIDTH-1:0]   mul_x, mul_y;
  logic [2*DWIDTH-1:0] prod;
  logic [RW-1:0]       prod_ext;
  logic [RW-1:0]       im_sum;

  // Operand mux idles at (0,0) so the multiplier does not toggle outside MUL_* states.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    case (state_reg)
      MUL_AC: begin mul_x = a_reg; mul_y = c_reg; end
      MUL_BD: begin mul_x = b_reg; mul_y = d_reg; end
      MUL_AD: begin mul_x = a_reg; mul_y = d_reg; end
      MUL_BC: begin mul_x = b_reg; mul_y = c_reg; end
      default: begin mul_x = '0; mul_y = '0; end
    endcase
  end

  cmplx_mult_seq_umul #(.DWIDTH(DWIDTH)) u_umul (
    .a (mul_x),
    .b (mul_y),
    .p (prod)
  );

  assign prod_ext = {1'b0, prod};
  assign im_sum   = im_acc_reg + prod_ext;

  // Results land in dedicated output registers so out_re/out_im stay put while the next job accumulates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      c_reg         <= '0;
      d_reg         <= '0;
      re_acc_reg    <= '0;
      im_acc_reg    <= '0;
      out_re_reg    <= '0;
      out_im_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= in_a;
            b_reg        <= in_b;
            c_reg        <= in_c;
            d_reg        <= in_d;
            in_ready_reg <= 1'b0;
            state_reg    <= MUL_AC;
          end
        end
        MUL_AC: begin
          re_acc_reg <= prod_ext;
          state_reg  <= MUL_BD;
        end
        MUL_BD: begin
          re_acc_reg <= re_acc_reg - prod_ext;
          state_reg  <= MUL_AD;
        end
        MUL_AD: begin
          im_acc_reg <= prod_ext;
          state_reg  <= MUL_BC;
        end
        MUL_BC: begin
          im_acc_reg    <= im_sum;
          out_re_reg    <= re_acc_reg;
          out_im_reg    <= im_sum;
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_re    = out_re_reg;
  assign out_im    = out_im_reg;

`ifdef CMPLX_MULT_SEQ_OPCNT_EN
  logic [15:0] op_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_reg <= '0;
    end else if (out_valid_reg && out_ready) begin
      op_count_reg <= op_count_reg + 16'd1;
    end
  end

  assign op_count = op_count_reg;
`endif

endmodule
